// File: rtl/branch_fetch_sequencer.sv
// Fetch-side PC owner: turns branch/jump decisions into PC redirects and IF/ID flushes,
// and stalls IF/ID on branch operand hazards the ID resolver cannot forward.
//
// state | meaning
// RUN   | normal fetch; hazards checked every cycle
// STALL | extra load-use stall cycles; scnt counts down to 1
module branch_fetch_sequencer #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter int          LOAD_STALL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        brSignal,
  input  logic        id_is_branch,
  input  logic        id_is_jump,
  input  logic [15:0] Imm,
  input  logic [25:0] j_index,
  input  logic [31:0] pc_id,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  WriteDst_EX,
  input  logic [4:0]  WriteDst_MEM,
  input  logic        EX_ctrl_RegWr,
  input  logic        MEM_ctrl_RegWr,
  input  logic        EX_ctrl_MemRd,
  input  logic        MEM_ctrl_MemRd,
  input  logic        ext_stall,
  output logic [31:0] pc,
  output logic        if_id_wr,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic [15:0] br_taken_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] SCNT_INIT = 2'(LOAD_STALL - 1);

  state_t      state;
  logic [1:0]  scnt;
  logic        h_ex;
  logic        h_mem;
  logic        stall;
  logic        take_jump;
  logic        take_br;
  logic        redirect;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] pc_next;

  assign h_ex = id_is_branch && EX_ctrl_RegWr && EX_ctrl_MemRd && (WriteDst_EX != 5'd0) &&
                ((rs == WriteDst_EX) || (rt == WriteDst_EX));

  // MEM-stage ALU results are not on the resolver's forward path; MEM loads are.
  assign h_mem = id_is_branch && MEM_ctrl_RegWr && !MEM_ctrl_MemRd && (WriteDst_MEM != 5'd0) &&
                 ((rs == WriteDst_MEM) || (rt == WriteDst_MEM));

  // Gated by rst so the combinational outputs read as a plain fetch while in reset.
  assign stall = rst && (ext_stall || (state == STALL) || h_ex || h_mem);

  assign take_jump = rst && !stall && id_is_jump;
  assign take_br   = rst && !stall && !id_is_jump && id_is_branch && brSignal;
  assign redirect  = take_jump || take_br;

  assign br_target = pc_id + 32'd4 + {{14{Imm[15]}}, Imm, 2'b00};
  assign j_target  = {pc_id[31:28], j_index, 2'b00};

  always_comb begin
    pc_next = pc + 32'd4;
    if (take_jump)    pc_next = j_target;
    else if (take_br) pc_next = br_target;
  end

  assign if_id_wr     = !stall;
  assign if_id_flush  = redirect;
  assign id_ex_bubble = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      scnt         <= 2'd0;
      pc           <= PC_RESET;
      br_taken_cnt <= 16'd0;
    end else begin
      if (!stall) pc <= pc_next;
      if (redirect && (br_taken_cnt != 16'hFFFF)) br_taken_cnt <= br_taken_cnt + 16'd1;
      // An external stall freezes the FSM, including any pending STALL count.
      if (!ext_stall) begin
        case (state)
          RUN: begin
            if (h_ex && (LOAD_STALL > 1)) begin
              state <= STALL;
              scnt  <= SCNT_INIT;
            end
          end
          STALL: begin
            if (scnt <= 2'd1) begin
              state <= RUN;
              scnt  <= 2'd0;
            end else begin
              scnt <= scnt - 2'd1;
            end
          end
          default: begin
            state <= RUN;
            scnt  <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_fetch_sequencer.sv
// Directed bench for branch_fetch_sequencer (LOAD_STALL=2): redirects, hazards,
// external stalls, counter saturation and reset behaviour.
module tb_branch_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        brSignal, id_is_branch, id_is_jump;
  logic [15:0] Imm;
  logic [25:0] j_index;
  logic [31:0] pc_id;
  logic [4:0]  rs, rt, WriteDst_EX, WriteDst_MEM;
  logic        EX_ctrl_RegWr, MEM_ctrl_RegWr, EX_ctrl_MemRd, MEM_ctrl_MemRd;
  logic        ext_stall;
  logic [31:0] pc;
  logic        if_id_wr, if_id_flush, id_ex_bubble;
  logic [15:0] br_taken_cnt;

  int vectors = 0;
  int miscompares = 0;

  // {if_id_wr, if_id_flush, id_ex_bubble}
  logic [2:0] outs;
  assign outs = {if_id_wr, if_id_flush, id_ex_bubble};

  localparam logic [2:0] O_SEQ   = 3'b100;
  localparam logic [2:0] O_REDIR = 3'b110;
  localparam logic [2:0] O_STALL = 3'b001;

  always #5 clk = ~clk;

  branch_fetch_sequencer #(.PC_RESET(32'h0000_3000), .LOAD_STALL(2)) dut (
    .clk(clk), .rst(rst), .brSignal(brSignal), .id_is_branch(id_is_branch),
    .id_is_jump(id_is_jump), .Imm(Imm), .j_index(j_index), .pc_id(pc_id),
    .rs(rs), .rt(rt), .WriteDst_EX(WriteDst_EX), .WriteDst_MEM(WriteDst_MEM),
    .EX_ctrl_RegWr(EX_ctrl_RegWr), .MEM_ctrl_RegWr(MEM_ctrl_RegWr),
    .EX_ctrl_MemRd(EX_ctrl_MemRd), .MEM_ctrl_MemRd(MEM_ctrl_MemRd),
    .ext_stall(ext_stall), .pc(pc), .if_id_wr(if_id_wr), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .br_taken_cnt(br_taken_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    brSignal = 0; id_is_branch = 0; id_is_jump = 0; Imm = 16'h0; j_index = 26'h0;
    pc_id = 32'h0; rs = 0; rt = 0; WriteDst_EX = 0; WriteDst_MEM = 0;
    EX_ctrl_RegWr = 0; MEM_ctrl_RegWr = 0; EX_ctrl_MemRd = 0; MEM_ctrl_MemRd = 0;
    ext_stall = 0;
  endtask

  task automatic set_taken_branch();
    clear_inputs();
    pc_id = 32'h3010; Imm = 16'hFFFC; id_is_branch = 1; brSignal = 1;
  endtask

  task automatic set_ex_load_hazard();
    clear_inputs();
    pc_id = 32'h3010; Imm = 16'hFFFC; id_is_branch = 1; brSignal = 1; rs = 5'd8;
    EX_ctrl_RegWr = 1; EX_ctrl_MemRd = 1; WriteDst_EX = 5'd8;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    ext_stall = 1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (pc !== 32'h3000) begin $display("FAIL reset_pc got %h want %h", pc, 32'h3000); miscompares++; end
    vectors++;
    if (outs !== O_SEQ) begin $display("FAIL reset_outs got %b want %b", outs, O_SEQ); miscompares++; end
    vectors++;
    if (br_taken_cnt !== 16'd0) begin $display("FAIL reset_cnt got %h want 0", br_taken_cnt); miscompares++; end
    ext_stall = 0;
    rst = 1;
    #1;
    vectors++;
    if (pc !== 32'h3000) begin $display("FAIL release_pc got %h want %h", pc, 32'h3000); miscompares++; end
    tick();
    vectors++;
    if (pc !== 32'h3004) begin $display("FAIL first_seq_pc got %h want %h", pc, 32'h3004); miscompares++; end
  endtask

  task automatic test_taken_branch();
    set_taken_branch();
    #1;
    vectors++;
    if (outs !== O_REDIR) begin $display("FAIL taken_outs got %b want %b", outs, O_REDIR); miscompares++; end
    tick();
    vectors++;
    if (pc !== 32'h3004) begin $display("FAIL taken_pc got %h want %h", pc, 32'h3004); miscompares++; end
    vectors++;
    if (br_taken_cnt !== 16'd1) begin $display("FAIL taken_cnt got %0d want 1", br_taken_cnt); miscompares++; end
  endtask

  task automatic test_not_taken();
    set_taken_branch();
    brSignal = 0;
    #1;
    vectors++;
    if (outs !== O_SEQ) begin $display("FAIL nt_outs got %b want %b", outs, O_SEQ); miscompares++; end
    tick();
    vectors++;
    if (pc !== 32'h3008) begin $display("FAIL nt_pc got %h want %h", pc, 32'h3008); miscompares++; end
    clear_inputs();
    pc_id = 32'h3010; Imm = 16'hFFFC; brSignal = 1;
    #1;
    vectors++;
    if (outs !== O_SEQ) begin $display("FAIL br_no_branch_outs got %b want %b", outs, O_SEQ); miscompares++; end
    tick();
    vectors++;
    if (pc !== 32'h300C) begin $display("FAIL br_no_branch_pc got %h want %h", pc, 32'h300C); miscompares++; end
    vectors++;
    if (br_taken_cnt !== 16'd1) begin $display("FAIL nt_cnt got %0d want 1", br_taken_cnt); miscompares++; end
  endtask

  task automatic test_jump_vs_branch();
    set_taken_branch();
    id_is_jump = 1; j_index = 26'h0000100;
    #1;
    vectors++;
    if (outs !== O_REDIR) begin $display("FAIL jump_outs got %b want %b", outs, O_REDIR); miscompares++; end
    tick();
    vectors++;
    if (pc !== 32'h0000_0400) begin $display("FAIL jump_pc got %h want %h", pc, 32'h400); miscompares++; end
    vectors++;
    if (br_taken_cnt !== 16'd2) begin $display("FAIL jump_cnt got %0d want 2", br_taken_cnt); miscompares++; end
  endtask

  task automatic test_forwarding_cases();
    // EX ALU result: forwarded, no stall
    clear_inputs();
    id_is_branch = 1; rs = 5'd8; EX_ctrl_RegWr = 1; WriteDst_EX = 5'd8;
    #1;
    vectors++;
    if (outs !== O_SEQ) begin $display("FAIL ex_alu_outs got %b want %b", outs, O_SEQ); miscompares++; end
    tick();
    vectors++;
    if (pc !== 32'h404) begin $display("FAIL ex_alu_pc got %h want %h", pc, 32'h404); miscompares++; end
    // MEM ALU result on rt: one stall, jump and brSignal ignored
    clear_inputs();
    id_is_branch = 1; brSignal = 1; id_is_jump = 1; j_index = 26'h3FF; rt = 5'd9;
    MEM_ctrl_RegWr = 1; WriteDst_MEM = 5'd9;
    #1;
    vectors++;
    if (outs !== O_STALL) begin $display("FAIL h_mem_outs got %b want %b", outs, O_STALL); miscompares++; end
    tick();
    vectors++;
    if (pc !== 32'h404) begin $display("FAIL h_mem_pc got %h want %h", pc, 32'h404); miscompares++; end
    // $0 destination never hazards
    clear_inputs();
    id_is_branch = 1; MEM_ctrl_RegWr = 1; WriteDst_MEM = 5'd0;
    #1;
    vectors++;
    if (outs !== O_SEQ) begin $display("FAIL zero_dst_outs got %b want %b", outs, O_SEQ); miscompares++; end
    tick();
    // MEM load result is forwardable
    clear_inputs();
    id_is_branch = 1; rt = 5'd9; MEM_ctrl_RegWr = 1; MEM_ctrl_MemRd = 1; WriteDst_MEM = 5'd9;
    #1;
    vectors++;
    if (outs !== O_SEQ) begin $display("FAIL mem_load_outs got %b want %b", outs, O_SEQ); miscompares++; end
    tick();
    vectors++;
    if (pc !== 32'h40C) begin $display("FAIL fwd_end_pc got %h want %h", pc, 32'h40C); miscompares++; end
    vectors++;
    if (br_taken_cnt !== 16'd2) begin $display("FAIL fwd_cnt got %0d want 2", br_taken_cnt); miscompares++; end
  endtask

  task automatic test_load_use();
    set_ex_load_hazard();
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (outs !== O_STALL) begin $display("FAIL load_use_outs cyc %0d got %b want %b", i, outs, O_STALL); miscompares++; end
      tick();
      vectors++;
      if (pc !== 32'h40C) begin $display("FAIL load_use_pc cyc %0d got %h want %h", i, pc, 32'h40C); miscompares++; end
      set_taken_branch();
      rs = 5'd8; MEM_ctrl_RegWr = 1; MEM_ctrl_MemRd = 1; WriteDst_MEM = 5'd8;
    end
    #1;
    vectors++;
    if (outs !== O_REDIR) begin $display("FAIL load_use_resolve got %b want %b", outs, O_REDIR); miscompares++; end
    tick();
    vectors++;
    if (pc !== 32'h3004) begin $display("FAIL load_use_target got %h want %h", pc, 32'h3004); miscompares++; end
    vectors++;
    if (br_taken_cnt !== 16'd3) begin $display("FAIL load_use_cnt got %0d want 3", br_taken_cnt); miscompares++; end
  endtask

  task automatic test_ext_stall();
    // expected outputs per cycle: RUN ext, H_EX, STALL+ext, STALL+ext, STALL, RUN
    logic [2:0] exp_o [6] = '{O_STALL, O_STALL, O_STALL, O_STALL, O_STALL, O_SEQ};
    logic       ext_v [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (i == 1) set_ex_load_hazard();
      else clear_inputs();
      ext_stall = ext_v[i];
      #1;
      vectors++;
      if (outs !== exp_o[i]) begin $display("FAIL ext_stall_outs cyc %0d got %b want %b", i, outs, exp_o[i]); miscompares++; end
      tick();
    end
    vectors++;
    if (pc !== 32'h3008) begin $display("FAIL ext_stall_pc got %h want %h", pc, 32'h3008); miscompares++; end
    vectors++;
    if (br_taken_cnt !== 16'd3) begin $display("FAIL ext_stall_cnt got %0d want 3", br_taken_cnt); miscompares++; end
  endtask

  task automatic test_saturation();
    set_taken_branch();
    repeat (65531) tick();
    vectors++;
    if (br_taken_cnt !== 16'hFFFE) begin $display("FAIL sat_pre got %h want FFFE", br_taken_cnt); miscompares++; end
    tick();
    vectors++;
    if (br_taken_cnt !== 16'hFFFF) begin $display("FAIL sat_reach got %h want FFFF", br_taken_cnt); miscompares++; end
    repeat (2) tick();
    vectors++;
    if (br_taken_cnt !== 16'hFFFF) begin $display("FAIL sat_hold got %h want FFFF", br_taken_cnt); miscompares++; end
    vectors++;
    if (pc !== 32'h3004) begin $display("FAIL sat_pc got %h want %h", pc, 32'h3004); miscompares++; end
  endtask

  task automatic test_reset_mid_stall();
    set_ex_load_hazard();
    #1;
    vectors++;
    if (outs !== O_STALL) begin $display("FAIL rms_enter got %b want %b", outs, O_STALL); miscompares++; end
    tick();
    clear_inputs();
    #1;
    vectors++;
    if (outs !== O_STALL) begin $display("FAIL rms_in_stall got %b want %b", outs, O_STALL); miscompares++; end
    rst = 0;
    #1;
    vectors++;
    if (pc !== 32'h3000) begin $display("FAIL rms_async_pc got %h want %h", pc, 32'h3000); miscompares++; end
    vectors++;
    if (br_taken_cnt !== 16'd0) begin $display("FAIL rms_cnt got %h want 0", br_taken_cnt); miscompares++; end
    rst = 1;
    #1;
    vectors++;
    if (outs !== O_SEQ) begin $display("FAIL rms_after got %b want %b", outs, O_SEQ); miscompares++; end
    tick();
    vectors++;
    if (pc !== 32'h3004) begin $display("FAIL rms_next_pc got %h want %h", pc, 32'h3004); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_taken_branch();
    test_not_taken();
    test_jump_vs_branch();
    test_forwarding_cases();
    test_load_use();
    test_ext_stall();
    test_saturation();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_fetch_sequencer.md
# branch_fetch_sequencer

Fetch-side counterpart to the ID-stage branch resolver. Owns the program counter and turns the resolver's taken/not-taken decision (plus J-type jumps) into a PC redirect and an IF/ID flush. Detects branch operand hazards the resolver's forwarding cannot cover and stalls IF/ID until the operand is forwardable. Also keeps a saturating count of taken redirects for performance debug.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- LOAD_STALL, 1, stall cycles inserted for a branch whose rs/rt is the destination of a load in EX (legal 1..3).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- brSignal  in  1  branch taken, from the ID-stage resolver.
- id_is_branch  in  1  ID instruction is BEQ/BNE.
- id_is_jump  in  1  ID instruction is J/JAL.
- Imm  in  16  ID branch offset (word offset, signed).
- j_index  in  26  ID jump index.
- pc_id  in  32  PC of the instruction in ID.
- rs, rt  in  5 each  ID source registers.
- WriteDst_EX, WriteDst_MEM  in  5 each  destination register in EX / MEM.
- EX_ctrl_RegWr, MEM_ctrl_RegWr  in  1 each  register write enable in EX / MEM.
- EX_ctrl_MemRd, MEM_ctrl_MemRd  in  1 each  stage holds a load.
- ext_stall  in  1  stall request from the general load-use unit.
- pc  out  32  registered fetch PC to imem.
- if_id_wr  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID loads a NOP at the next edge.
- id_ex_bubble  out  1  ID/EX loads a bubble at the next edge.
- br_taken_cnt  out  16  saturating count of taken redirects (branches and jumps).

## Operation
- Branch target: pc_id + 4 + (sign_extend(Imm) << 2), computed in 32-bit with wrap-around.
- Jump target: {pc_id[31:28], j_index, 2'b00}.
- Hazard condition H_EX (branches only): id_is_branch, EX_ctrl_RegWr, EX_ctrl_MemRd, WriteDst_EX != 0, and (rs or rt) == WriteDst_EX.
- Hazard condition H_MEM (branches only): id_is_branch, MEM_ctrl_RegWr, !MEM_ctrl_MemRd, WriteDst_MEM != 0, and (rs or rt) == WriteDst_MEM. MEM-stage ALU results are not on the resolver's forward path.
- ALU results in EX are forwarded by the resolver and are not a hazard.
- FSM states:
  - RUN: default state.
  - STALL: holds a 2-bit down-counter scnt.
- RUN transitions:
  - H_EX: stall this cycle; if LOAD_STALL > 1, go to STALL with scnt = LOAD_STALL-1.
  - H_MEM: stall this cycle; stay in RUN.
  - Otherwise: no stall.
- STALL behaviour: stall every cycle. Decrement scnt each cycle; return to RUN when scnt reaches 1.
- Stall cycle outputs:
  - if_id_wr=0, id_ex_bubble=1, pc holds.
  - brSignal and id_is_jump are ignored (operands are stale).
  - if_id_flush=0.
- ext_stall: treated as a stall cycle (same outputs) but does not change FSM state or scnt. A pending STALL count freezes while ext_stall=1.
- Non-stall cycle, redirect priority jump > branch > sequential:
  - id_is_jump=1: pc <= jump target, if_id_flush=1.
  - id_is_branch and brSignal=1: pc <= branch target, if_id_flush=1.
  - Otherwise: pc <= pc + 4, if_id_flush=0.
  - In all cases if_id_wr=1 and id_ex_bubble=0.
- brSignal with id_is_branch=0 is ignored.
- br_taken_cnt increments on each non-stall redirect and saturates at 16'hFFFF.

## Timing
- Reset (rst=0, asynchronous): pc=PC_RESET, state=RUN, scnt=0, br_taken_cnt=0.
- Combinational outputs during reset: if_id_wr=1, if_id_flush=0, id_ex_bubble=0.
- if_id_wr, if_id_flush and id_ex_bubble are combinational in the same cycle as the decision.
- pc updates at the following edge. A redirect decided in cycle N gives pc=target in N+1, and the wrong-path fetch of N is squashed (one-cycle branch penalty).
- H_EX with LOAD_STALL=1: one stall cycle. The branch resolves in the next cycle using the forwarded dm_dout.
- Reset deasserted mid-STALL: the FSM is simply back in RUN; no residual stall.
- Counter update and pc update share the same edge.

## Test plan
- Reset: rst=0 for 3 cycles, then release -> pc=32'h3000, pc=32'h3004 one cycle later, br_taken_cnt=0.
- Taken branch: pc_id=32'h3010, Imm=16'hFFFC, brSignal=1 -> if_id_flush=1 that cycle, pc=32'h3004 next cycle, br_taken_cnt=1.
- Jump vs branch together: id_is_jump=1, j_index=26'h0000100, brSignal=1 -> pc=32'h0000_0400; exactly one count.
- Load-use on branch with LOAD_STALL=2: EX load to $8, BEQ rs=$8 -> two cycles of if_id_wr=0 / id_ex_bubble=1 with pc frozen; third cycle resolves per brSignal.
- ext_stall during STALL: ext_stall raised in first STALL cycle -> stall lengthens by ext_stall duration; scnt frozen.
- Counter saturation and reset mid-stall: preload via 65,535 taken branches, one more -> cnt stays 16'hFFFF; assert rst during STALL -> next-cycle outputs are non-stall and pc=PC_RESET.
